// File: rtl/axi_s_if.sv
// Slave-side R/B response demux to two masters via 2-entry in-order FIFOs, ID[4] selects master.
// Latency: one cycle from push to Mx_*_VALID; READY low when FIFO full, heads wait for their master.
// Optional outstanding-transaction tracking under `AXI_S_IF_OTC_EN (stall at 7, sticky ERR_o).
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif

module axi_s_if (
    input  logic                      AXI_CLK_i,
    input  logic                      AXI_RST_i,
    input  logic [`AXI_IDS_BITS-1:0]  RID_i,
    input  logic [`AXI_DATA_BITS-1:0] RDATA_i,
    input  logic [1:0]                RRESP_i,
    input  logic                      RLAST_i,
    input  logic                      RVALID_i,
    output logic                      RREADY_o,
    input  logic [`AXI_IDS_BITS-1:0]  BID_i,
    input  logic [1:0]                BRESP_i,
    input  logic                      BVALID_i,
    output logic                      BREADY_o,
    output logic                      M0_R_VALID,
    output logic [38:0]               M0_R_DATA,
    output logic                      M0_B_VALID,
    output logic [5:0]                M0_B_DATA,
    output logic                      M1_R_VALID,
    output logic [38:0]               M1_R_DATA,
    output logic                      M1_B_VALID,
    output logic [5:0]                M1_B_DATA,
    input  logic                      M0_R_READY,
    input  logic                      M0_B_READY,
    input  logic                      M0_AR_ACC,
    input  logic                      M0_AW_ACC,
    input  logic                      M1_R_READY,
    input  logic                      M1_B_READY,
    input  logic                      M1_AR_ACC,
    input  logic                      M1_AW_ACC,
    output logic                      M0_AR_STALL,
    output logic                      M0_AW_STALL,
    output logic                      M1_AR_STALL,
    output logic                      M1_AW_STALL,
    output logic                      ERR_o
);

    // Entries carry the route bit on top of the forwarded payload.
    logic [39:0] r_mem [0:1];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_cnt;
    logic [39:0] r_head;
    logic        r_push;
    logic        r_pop;
    logic        r_nonempty;

    logic [6:0]  b_mem [0:1];
    logic        b_wr_ptr;
    logic        b_rd_ptr;
    logic [1:0]  b_cnt;
    logic [6:0]  b_head;
    logic        b_push;
    logic        b_pop;
    logic        b_nonempty;

    assign RREADY_o   = (r_cnt < 2'd2);
    assign r_push     = RVALID_i & RREADY_o;
    assign r_head     = r_mem[r_rd_ptr];
    assign r_nonempty = (r_cnt != 2'd0);
    assign M0_R_VALID = r_nonempty & ~r_head[39];
    assign M1_R_VALID = r_nonempty &  r_head[39];
    assign M0_R_DATA  = M0_R_VALID ? r_head[38:0] : 39'd0;
    assign M1_R_DATA  = M1_R_VALID ? r_head[38:0] : 39'd0;
    assign r_pop      = (M0_R_VALID & M0_R_READY) | (M1_R_VALID & M1_R_READY);

    assign BREADY_o   = (b_cnt < 2'd2);
    assign b_push     = BVALID_i & BREADY_o;
    assign b_head     = b_mem[b_rd_ptr];
    assign b_nonempty = (b_cnt != 2'd0);
    assign M0_B_VALID = b_nonempty & ~b_head[6];
    assign M1_B_VALID = b_nonempty &  b_head[6];
    assign M0_B_DATA  = M0_B_VALID ? b_head[5:0] : 6'd0;
    assign M1_B_DATA  = M1_B_VALID ? b_head[5:0] : 6'd0;
    assign b_pop      = (M0_B_VALID & M0_B_READY) | (M1_B_VALID & M1_B_READY);

    // Storage needs no reset: outputs are gated by the count.
    always_ff @(posedge AXI_CLK_i) begin
        if (r_push)
            r_mem[r_wr_ptr] <= {RID_i[4], RID_i[3:0], RDATA_i, RRESP_i, RLAST_i};
        if (b_push)
            b_mem[b_wr_ptr] <= {BID_i[4], BID_i[3:0], BRESP_i};
    end

    always_ff @(posedge AXI_CLK_i) begin
        if (AXI_RST_i) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_cnt    <= 2'd0;
            b_wr_ptr <= 1'b0;
            b_rd_ptr <= 1'b0;
            b_cnt    <= 2'd0;
        end else begin
            if (r_push) r_wr_ptr <= ~r_wr_ptr;
            if (r_pop)  r_rd_ptr <= ~r_rd_ptr;
            if (r_push && !r_pop)      r_cnt <= r_cnt + 2'd1;
            else if (!r_push && r_pop) r_cnt <= r_cnt - 2'd1;
            if (b_push) b_wr_ptr <= ~b_wr_ptr;
            if (b_pop)  b_rd_ptr <= ~b_rd_ptr;
            if (b_push && !b_pop)      b_cnt <= b_cnt + 2'd1;
            else if (!b_push && b_pop) b_cnt <= b_cnt - 2'd1;
        end
    end

`ifdef AXI_S_IF_OTC_EN
    logic [2:0] rd_cnt0, rd_cnt1, wr_cnt0, wr_cnt1;
    logic [3:0] rd_nxt0, rd_nxt1, wr_nxt0, wr_nxt1;
    logic       err;

    // Returns {error, next_count}; saturates at both ends.
    function automatic logic [3:0] cnt_next(input logic [2:0] c, input logic inc, input logic dec);
        logic [3:0] res;
        res = {1'b0, c};
        if (inc && !dec) begin
            if (c == 3'd7) res = {1'b1, c};
            else           res = {1'b0, c + 3'd1};
        end else if (dec && !inc) begin
            if (c == 3'd0) res = {1'b1, c};
            else           res = {1'b0, c - 3'd1};
        end
        return res;
    endfunction

    assign rd_nxt0 = cnt_next(rd_cnt0, M0_AR_ACC, r_push & RLAST_i & ~RID_i[4]);
    assign rd_nxt1 = cnt_next(rd_cnt1, M1_AR_ACC, r_push & RLAST_i &  RID_i[4]);
    assign wr_nxt0 = cnt_next(wr_cnt0, M0_AW_ACC, b_push & ~BID_i[4]);
    assign wr_nxt1 = cnt_next(wr_cnt1, M1_AW_ACC, b_push &  BID_i[4]);

    always_ff @(posedge AXI_CLK_i) begin
        if (AXI_RST_i) begin
            rd_cnt0 <= 3'd0;
            rd_cnt1 <= 3'd0;
            wr_cnt0 <= 3'd0;
            wr_cnt1 <= 3'd0;
            err     <= 1'b0;
        end else begin
            rd_cnt0 <= rd_nxt0[2:0];
            rd_cnt1 <= rd_nxt1[2:0];
            wr_cnt0 <= wr_nxt0[2:0];
            wr_cnt1 <= wr_nxt1[2:0];
            err     <= err | rd_nxt0[3] | rd_nxt1[3] | wr_nxt0[3] | wr_nxt1[3];
        end
    end

    assign M0_AR_STALL = (rd_cnt0 == 3'd7);
    assign M1_AR_STALL = (rd_cnt1 == 3'd7);
    assign M0_AW_STALL = (wr_cnt0 == 3'd7);
    assign M1_AW_STALL = (wr_cnt1 == 3'd7);
    assign ERR_o       = err;

    logic unused;
    assign unused = ^{RID_i[7:5], BID_i[7:5]};
`else
    assign M0_AR_STALL = 1'b0;
    assign M1_AR_STALL = 1'b0;
    assign M0_AW_STALL = 1'b0;
    assign M1_AW_STALL = 1'b0;
    assign ERR_o       = 1'b0;

    logic unused;
    assign unused = ^{RID_i[7:5], BID_i[7:5], M0_AR_ACC, M0_AW_ACC, M1_AR_ACC, M1_AW_ACC};
`endif

endmodule

// File: tb/tb_axi_s_if.sv
// Directed bench for axi_s_if: routing, ordering, backpressure, reset and optional outstanding tracking.
module tb_axi_s_if;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic [7:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic        m0_r_valid, m1_r_valid, m0_b_valid, m1_b_valid;
    logic [38:0] m0_r_data, m1_r_data;
    logic [5:0]  m0_b_data, m1_b_data;
    logic        m0_r_ready, m1_r_ready, m0_b_ready, m1_b_ready;
    logic        m0_ar_acc, m1_ar_acc, m0_aw_acc, m1_aw_acc;
    logic        m0_ar_stall, m1_ar_stall, m0_aw_stall, m1_aw_stall, err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    axi_s_if dut (
        .AXI_CLK_i(clk), .AXI_RST_i(rst),
        .RID_i(rid), .RDATA_i(rdata), .RRESP_i(rresp), .RLAST_i(rlast), .RVALID_i(rvalid), .RREADY_o(rready),
        .BID_i(bid), .BRESP_i(bresp), .BVALID_i(bvalid), .BREADY_o(bready),
        .M0_R_VALID(m0_r_valid), .M0_R_DATA(m0_r_data), .M0_B_VALID(m0_b_valid), .M0_B_DATA(m0_b_data),
        .M1_R_VALID(m1_r_valid), .M1_R_DATA(m1_r_data), .M1_B_VALID(m1_b_valid), .M1_B_DATA(m1_b_data),
        .M0_R_READY(m0_r_ready), .M0_B_READY(m0_b_ready), .M0_AR_ACC(m0_ar_acc), .M0_AW_ACC(m0_aw_acc),
        .M1_R_READY(m1_r_ready), .M1_B_READY(m1_b_ready), .M1_AR_ACC(m1_ar_acc), .M1_AW_ACC(m1_aw_acc),
        .M0_AR_STALL(m0_ar_stall), .M0_AW_STALL(m0_aw_stall),
        .M1_AR_STALL(m1_ar_stall), .M1_AW_STALL(m1_aw_stall), .ERR_o(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rid = '0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0;
        bid = '0; bresp = '0; bvalid = 0;
        m0_r_ready = 0; m1_r_ready = 0; m0_b_ready = 0; m1_b_ready = 0;
        m0_ar_acc = 0; m1_ar_acc = 0; m0_aw_acc = 0; m1_aw_acc = 0;
        rst = 1'b1;
        tick();
        do_reset();

        check("rst_m0_r_valid", m0_r_valid, 0);
        check("rst_m1_r_valid", m1_r_valid, 0);
        check("rst_m0_r_data", m0_r_data, 0);
        check("rst_m0_b_valid", m0_b_valid, 0);
        check("rst_m1_b_data", m1_b_data, 0);
        check("rst_rready", rready, 1);
        check("rst_bready", bready, 1);
        check("rst_err", err, 0);
        check("rst_m0_ar_stall", m0_ar_stall, 0);

        // Single R to M1, visible the cycle after push
        rvalid = 1; rid = 8'h13; rdata = 32'hDEADBEEF; rresp = 2'b00; rlast = 1;
        tick();
        rvalid = 0; rlast = 0;
        check("r1_m1_valid", m1_r_valid, 1);
        check("r1_m1_data", m1_r_data, {4'h3, 32'hDEADBEEF, 2'b00, 1'b1});
        check("r1_m0_valid", m0_r_valid, 0);
        check("r1_m0_data", m0_r_data, 0);
        m1_r_ready = 1;
        tick();
        m1_r_ready = 0;
        check("r1_pop_valid", m1_r_valid, 0);
        check("r1_pop_data", m1_r_data, 0);

        // M0 head blocks M1 entry behind it
        rvalid = 1; rid = 8'h05; rdata = 32'hA5A5A5A5; rresp = 2'b00;
        tick();
        rid = 8'h10; rdata = 32'h5A5A5A5A;
        tick();
        rvalid = 0;
        check("blk_rready_full", rready, 0);
        check("blk_m0_valid", m0_r_valid, 1);
        check("blk_m1_valid", m1_r_valid, 0);
        check("blk_m0_data", m0_r_data, {4'h5, 32'hA5A5A5A5, 2'b00, 1'b0});
        m1_r_ready = 1;
        tick();
        check("blk_m0_hold", m0_r_valid, 1);
        check("blk_m1_still_blocked", m1_r_valid, 0);
        m0_r_ready = 1;
        tick();
        m0_r_ready = 0;
        check("blk_m0_popped", m0_r_valid, 0);
        check("blk_m1_now_valid", m1_r_valid, 1);
        check("blk_m1_data", m1_r_data, {4'h0, 32'h5A5A5A5A, 2'b00, 1'b0});
        check("blk_rready_one", rready, 1);
        tick();
        m1_r_ready = 0;
        check("blk_drained", m1_r_valid, 0);

        // ID[7:5] ignored; push+pop at count 1
        rvalid = 1; rid = 8'hE7; rdata = 32'h11111111; rresp = 2'b10;
        tick();
        check("hi_m0_valid", m0_r_valid, 1);
        check("hi_m0_data", m0_r_data, {4'h7, 32'h11111111, 2'b10, 1'b0});
        rid = 8'h11; rdata = 32'h22222222; rresp = 2'b01;
        m0_r_ready = 1;
        tick();
        rvalid = 0; m0_r_ready = 0;
        check("pp_m0_valid", m0_r_valid, 0);
        check("pp_m1_valid", m1_r_valid, 1);
        check("pp_m1_data", m1_r_data, {4'h1, 32'h22222222, 2'b01, 1'b0});
        check("pp_rready", rready, 1);
        m1_r_ready = 1;
        tick();
        m1_r_ready = 0;
        check("pp_drained", m1_r_valid, 0);

        // B: three pushes, third held off by backpressure
        bvalid = 1; bid = 8'h01; bresp = 2'b00;
        tick();
        bid = 8'h12; bresp = 2'b01;
        tick();
        check("b_bready_full", bready, 0);
        bid = 8'h05; bresp = 2'b11;
        tick();
        check("b_held_off", bready, 0);
        check("b_m0_valid", m0_b_valid, 1);
        check("b_m0_data", m0_b_data, 6'h04);
        check("b_m1_valid", m1_b_valid, 0);
        m0_b_ready = 1;
        tick();
        check("b_m0_popped", m0_b_valid, 0);
        check("b_m1_valid2", m1_b_valid, 1);
        check("b_m1_data", m1_b_data, 6'h09);
        check("b_bready_one", bready, 1);
        tick();
        bvalid = 0;
        check("b_m1_stable", m1_b_valid, 1);
        check("b_m1_data_stable", m1_b_data, 6'h09);
        check("b_m0_waits", m0_b_valid, 0);
        check("b_full_again", bready, 0);
        m1_b_ready = 1;
        tick();
        m1_b_ready = 0;
        check("b_m0_id5_valid", m0_b_valid, 1);
        check("b_m0_id5_data", m0_b_data, 6'h17);
        tick();
        m0_b_ready = 0;
        check("b_drained", m0_b_valid, 0);
        check("b_bready_empty", bready, 1);

`ifdef AXI_S_IF_OTC_EN
        do_reset();
        for (int i = 1; i <= 7; i++) begin
            m0_ar_acc = 1;
            tick();
            m0_ar_acc = 0;
            if (i == 6) check("otc_ar6_stall", m0_ar_stall, 0);
        end
        check("otc_ar7_stall", m0_ar_stall, 1);
        check("otc_ar7_err", err, 0);
        check("otc_m1_ar_stall", m1_ar_stall, 0);
        m0_ar_acc = 1;
        tick();
        m0_ar_acc = 0;
        check("otc_ar8_err", err, 1);
        check("otc_ar8_stall", m0_ar_stall, 1);

        do_reset();
        for (int i = 0; i < 2; i++) begin
            m1_aw_acc = 1;
            tick();
            m1_aw_acc = 0;
        end
        m1_aw_acc = 1; bvalid = 1; bid = 8'h10; bresp = 2'b00;
        tick();
        m1_aw_acc = 0; bvalid = 0;
        check("otc_incdec_b_valid", m1_b_valid, 1);
        check("otc_incdec_err", err, 0);
        m1_b_ready = 1;
        tick();
        m1_b_ready = 0;
        for (int i = 1; i <= 5; i++) begin
            m1_aw_acc = 1;
            tick();
            m1_aw_acc = 0;
            if (i == 4) check("otc_aw6_stall", m1_aw_stall, 0);
        end
        check("otc_aw7_stall", m1_aw_stall, 1);
        check("otc_aw7_err", err, 0);
        bvalid = 1; bid = 8'h01; bresp = 2'b00;
        tick();
        bvalid = 0;
        check("otc_under_err", err, 1);
        check("otc_under_delivered", m0_b_valid, 1);
        check("otc_under_data", m0_b_data, 6'h04);
        check("otc_m0_aw_stall", m0_aw_stall, 0);
        check("otc_reset_prep_stall", m1_aw_stall, 1);
`else
        for (int i = 0; i < 8; i++) begin
            m0_ar_acc = 1; m1_ar_acc = 1; m0_aw_acc = 1; m1_aw_acc = 1;
            tick();
            m0_ar_acc = 0; m1_ar_acc = 0; m0_aw_acc = 0; m1_aw_acc = 0;
        end
        check("noc_m0_ar_stall", m0_ar_stall, 0);
        check("noc_m1_ar_stall", m1_ar_stall, 0);
        check("noc_m0_aw_stall", m0_aw_stall, 0);
        check("noc_m1_aw_stall", m1_aw_stall, 0);
        check("noc_err", err, 0);
`endif

        // Reset mid-burst discards buffered entries
        m0_ar_acc = 1; rvalid = 1; rid = 8'h05; rdata = 32'h0BADF00D; rresp = 2'b00; rlast = 0;
        tick();
        rid = 8'h15;
        tick();
        m0_ar_acc = 0; rvalid = 0;
        check("mid_rready_full", rready, 0);
        check("mid_m0_valid", m0_r_valid, 1);
        do_reset();
        check("mid_m0_r_valid", m0_r_valid, 0);
        check("mid_m1_r_valid", m1_r_valid, 0);
        check("mid_m0_b_valid", m0_b_valid, 0);
        check("mid_m1_b_valid", m1_b_valid, 0);
        check("mid_m0_r_data", m0_r_data, 0);
        check("mid_rready", rready, 1);
        check("mid_bready", bready, 1);
        check("mid_m0_ar_stall", m0_ar_stall, 0);
        check("mid_m1_aw_stall", m1_aw_stall, 0);
        check("mid_err", err, 0);
        m0_r_ready = 1; m1_r_ready = 1;
        tick();
        m0_r_ready = 0; m1_r_ready = 0;
        check("mid_no_drain", m0_r_valid | m1_r_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
